// File: rtl/float_maxpool_2x2.sv
// ============================================================================
// Module      : float_maxpool_2x2
// Description : Streaming 2x2, stride-2 max-pool on IEEE-754 single-precision
//               pixels. Consumes one channel plane in raster order. A
//               half-row line buffer holds the horizontal maxima of each even
//               row, and the block emits one pooled pixel per 2x2 window.
//               Optional macro FLOAT_MAXPOOL_NAN_FLUSH_EN replaces NaN inputs
//               with +0.0 before they enter the compare path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module float_maxpool_2x2 #(
  parameter int IMG_W = 416,
  parameter int IMG_H = 416,
  parameter int CW    = 9,
  parameter int RW    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        in_valid,
  input  logic [31:0] in_float,
  output logic        out_valid,
  output logic [31:0] out_float,
  output logic        frame_done,
  output logic        busy
);

  localparam int HALF_W = IMG_W / 2;
  localparam int IW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  localparam logic [CW-1:0] c_last_col = CW'(IMG_W - 1);
  localparam logic [RW-1:0] c_last_row = RW'(IMG_H - 1);
  localparam logic [CW-1:0] c_col_one  = CW'(1);
  localparam logic [RW-1:0] c_row_one  = RW'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EVEN_ROW = 2'd1,
    S_ODD_ROW  = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [31:0]     r_pair;
  logic [31:0]     r_linebuf [HALF_W];

  state_t          w_state;
  logic [CW-1:0]   w_col;
  logic [RW-1:0]   w_row;
  logic [IW-1:0]   w_idx;
  logic            w_accept;
  logic [31:0]     w_in;
  logic [31:0]     w_h;
  logic [31:0]     w_res;

  // Bit-field max: sign decides first, then magnitude order flips for negatives.
  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31])
      fmax = a[31] ? b : a;
    else if (!a[31])
      fmax = (a[30:0] >= b[30:0]) ? a : b;
    else
      fmax = (a[30:0] <= b[30:0]) ? a : b;
  endfunction

`ifdef FLOAT_MAXPOOL_NAN_FLUSH_EN
  // NaN patterns are flushed to +0.0; infinities pass through.
  assign w_in = ((in_float[30:23] == 8'hFF) && (in_float[22:0] != 23'd0)) ? 32'h0000_0000 : in_float;
`else
  assign w_in = in_float;
`endif

  // A frame_start restarts the plane this very cycle, so the sample it
  // qualifies is treated as pixel (0,0) of an even row.
  assign w_state  = frame_start ? S_EVEN_ROW : r_state;
  assign w_col    = frame_start ? '0 : r_col;
  assign w_row    = frame_start ? '0 : r_row;
  assign w_idx    = IW'(w_col >> 1);
  assign w_accept = in_valid && (w_state != S_IDLE);
  assign w_h      = fmax(r_pair, w_in);
  assign w_res    = fmax(r_linebuf[w_idx], w_h);
  assign busy     = (r_state != S_IDLE);

  // Datapath storage: pair register and line buffer need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (!w_col[0])
        r_pair <= w_in;
      else if (w_state == S_EVEN_ROW)
        r_linebuf[w_idx] <= w_h;
    end
  end

  // Control FSM, position counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      out_valid  <= 1'b0;
      out_float  <= 32'h0000_0000;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start) begin
        r_state <= S_EVEN_ROW;
        r_col   <= '0;
        r_row   <= '0;
      end
      if (w_accept) begin
        if (w_col[0] && (w_state == S_ODD_ROW)) begin
          out_valid  <= 1'b1;
          out_float  <= w_res;
          frame_done <= (w_col == c_last_col) && (w_row == c_last_row);
        end
        if (w_col == c_last_col) begin
          r_col <= '0;
          if (w_state == S_EVEN_ROW) begin
            r_state <= S_ODD_ROW;
            r_row   <= w_row + c_row_one;
          end else if (w_row == c_last_row) begin
            r_state <= S_IDLE;
            r_row   <= '0;
          end else begin
            r_state <= S_EVEN_ROW;
            r_row   <= w_row + c_row_one;
          end
        end else begin
          r_col <= w_col + c_col_one;
        end
      end
    end
  end

endmodule

`default_nettype wire
